// File: rtl/snake_motion_ctrl.sv
// Four-segment snake motion controller: IDLE/RUN/OVER FSM that advances the snake on frame ticks.
// Define SNAKE_WRAP_EN to wrap the head around the play-field edges instead of ending the game.
module snake_motion_ctrl #(
  parameter int STEP            = 10,
  parameter int FRAMES_PER_MOVE = 15,
  parameter int X_MIN           = 5,
  parameter int X_MAX           = 634,
  parameter int Y_MIN           = 5,
  parameter int Y_MAX           = 474,
  parameter int START_X         = 320,
  parameter int START_Y         = 240
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [9:0] snake_x1,
  output logic [9:0] snake_x2,
  output logic [9:0] snake_x3,
  output logic [9:0] snake_x4,
  output logic [9:0] snake_y1,
  output logic [9:0] snake_y2,
  output logic [9:0] snake_y3,
  output logic [9:0] snake_y4,
  output logic       black,
  output logic       game_over
);

  localparam int unsigned PW   = 10;
  localparam int unsigned CW   = 8;
  localparam int unsigned SW   = 11;
  localparam int unsigned NSEG = 4;

  localparam logic signed [SW-1:0] STEP_S  = SW'(STEP);
  localparam logic signed [SW-1:0] XMIN_S  = SW'(X_MIN);
  localparam logic signed [SW-1:0] XMAX_S  = SW'(X_MAX);
  localparam logic signed [SW-1:0] YMIN_S  = SW'(Y_MIN);
  localparam logic signed [SW-1:0] YMAX_S  = SW'(Y_MAX);
  localparam logic [CW-1:0]        CNT_LAST = CW'(FRAMES_PER_MOVE - 1);

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
  typedef logic [NSEG-1:0][PW-1:0] seg_t;

  state_t                 state, state_nxt;
  dir_t                   dir, dir_nxt, pend, pend_nxt, req_dir;
  logic                   req_valid, move, hit;
  logic [CW-1:0]          cnt, cnt_nxt;
  seg_t                   seg_x, seg_x_nxt, seg_y, seg_y_nxt;
  logic signed [SW-1:0]   next_x, next_y;
  logic                   black_nxt, game_over_nxt;

  // Start-of-game body: horizontal line trailing to the left of the head.
  function automatic seg_t init_x();
    seg_t v;
    for (int unsigned i = 0; i < NSEG; i++) v[i] = PW'(START_X - int'(i) * STEP);
    return v;
  endfunction

  function automatic seg_t init_y();
    seg_t v;
    for (int unsigned i = 0; i < NSEG; i++) v[i] = PW'(START_Y);
    return v;
  endfunction

  function automatic logic opposite(dir_t a, dir_t b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

  always_comb begin
    req_valid = 1'b1;
    req_dir   = DIR_RIGHT;
    if (btn_up)         req_dir = DIR_UP;
    else if (btn_down)  req_dir = DIR_DOWN;
    else if (btn_left)  req_dir = DIR_LEFT;
    else if (btn_right) req_dir = DIR_RIGHT;
    else                req_valid = 1'b0;
  end

  // Candidate head in signed arithmetic so stepping past zero reads as a wall hit.
  always_comb begin
    next_x = $signed({1'b0, seg_x[0]});
    next_y = $signed({1'b0, seg_y[0]});
    hit    = 1'b0;
    case (pend)
      DIR_UP:    next_y = next_y - STEP_S;
      DIR_DOWN:  next_y = next_y + STEP_S;
      DIR_LEFT:  next_x = next_x - STEP_S;
      default:   next_x = next_x + STEP_S;
    endcase
`ifdef SNAKE_WRAP_EN
    if (next_x > XMAX_S)      next_x = XMIN_S;
    else if (next_x < XMIN_S) next_x = XMAX_S;
    if (next_y > YMAX_S)      next_y = YMIN_S;
    else if (next_y < YMIN_S) next_y = YMAX_S;
`else
    if ((next_x < XMIN_S) || (next_x > XMAX_S) || (next_y < YMIN_S) || (next_y > YMAX_S))
      hit = 1'b1;
`endif
    if (((PW'(next_x) == seg_x[1]) && (PW'(next_y) == seg_y[1])) ||
        ((PW'(next_x) == seg_x[2]) && (PW'(next_y) == seg_y[2])))
      hit = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    pend_nxt  = pend;
    cnt_nxt   = cnt;
    seg_x_nxt = seg_x;
    seg_y_nxt = seg_y;
    move      = 1'b0;
    case (state)
      IDLE, OVER: begin
        if (start) begin
          state_nxt = RUN;
          dir_nxt   = DIR_RIGHT;
          pend_nxt  = DIR_RIGHT;
          cnt_nxt   = '0;
          seg_x_nxt = init_x();
          seg_y_nxt = init_y();
        end
      end
      RUN: begin
        if (frame_tick) begin
          if (cnt == CNT_LAST) begin
            cnt_nxt = '0;
            move    = 1'b1;
            if (hit) begin
              state_nxt = OVER;
            end else begin
              seg_x_nxt = {seg_x[NSEG-2:0], PW'(next_x)};
              seg_y_nxt = {seg_y[NSEG-2:0], PW'(next_y)};
              dir_nxt   = pend;
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        // Reversal test uses the direction in force after this cycle.
        if (req_valid && !opposite(req_dir, move ? pend : dir)) pend_nxt = req_dir;
      end
      default: state_nxt = IDLE;
    endcase
    black_nxt     = (state_nxt == IDLE);
    game_over_nxt = (state_nxt == OVER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dir       <= DIR_RIGHT;
      pend      <= DIR_RIGHT;
      cnt       <= '0;
      seg_x     <= init_x();
      seg_y     <= init_y();
      black     <= 1'b1;
      game_over <= 1'b0;
    end else begin
      state     <= state_nxt;
      dir       <= dir_nxt;
      pend      <= pend_nxt;
      cnt       <= cnt_nxt;
      seg_x     <= seg_x_nxt;
      seg_y     <= seg_y_nxt;
      black     <= black_nxt;
      game_over <= game_over_nxt;
    end
  end

  assign snake_x1 = seg_x[0];
  assign snake_x2 = seg_x[1];
  assign snake_x3 = seg_x[2];
  assign snake_x4 = seg_x[3];
  assign snake_y1 = seg_y[0];
  assign snake_y2 = seg_y[1];
  assign snake_y3 = seg_y[2];
  assign snake_y4 = seg_y[3];

endmodule

// File: doc/snake_motion_ctrl.md
SNAKE_MOTION_CTRL -- requirements
Module: snake_motion_ctrl

Interface
REQ-001 SHALL have parameter STEP, default 10: pixel pitch between segments and per-move head displacement.
REQ-002 SHALL have parameter FRAMES_PER_MOVE, default 15: number of frame_tick pulses per move, legal range 1..255.
REQ-003 SHALL have parameters X_MIN/X_MAX, defaults 5/634, and Y_MIN/Y_MAX, defaults 5/474: legal head-centre bounds, inclusive.
REQ-004 SHALL have parameters START_X/START_Y, defaults 320/240: head position after reset or restart.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port frame_tick, input, 1 bit: one-cycle pulse per video frame.
REQ-008 SHALL have port start, input, 1 bit: level input, sampled every cycle.
REQ-009 SHALL have ports btn_up, btn_down, btn_left, btn_right, input, 1 bit each: direction requests, already debounced.
REQ-010 SHALL have ports snake_x1..snake_x4 and snake_y1..snake_y4, output, 10 bits each: segment centres; 1 is the head.
REQ-011 SHALL have port black, output, 1 bit: blank-screen request to the pixel colour stage.
REQ-012 SHALL have port game_over, output, 1 bit: high while in state OVER.

Function
REQ-013 SHALL implement three states: IDLE, RUN, OVER; all outputs registered.
REQ-014 SHALL set black=1 in IDLE and black=0 in RUN and OVER.
REQ-015 IDLE, or OVER, with start=1 SHALL load initial positions, clear the frame counter, set direction RIGHT, and enter RUN next cycle; a frame_tick in that cycle is ignored.
REQ-016 In RUN, each frame_tick SHALL increment an 8-bit frame counter; the tick on which count equals FRAMES_PER_MOVE-1 SHALL instead clear it and perform a move.
REQ-017 A move SHALL update all segments in the same cycle: seg4<=seg3, seg3<=seg2, seg2<=seg1, head<=head+/-STEP per committed direction; outputs change 1 cycle after the tick.
REQ-018 Button presses SHALL latch into a pending direction every cycle; simultaneous presses SHALL resolve with priority up>down>left>right.
REQ-019 A pending direction opposite to the committed direction SHALL be discarded; the pending direction commits only at a move.
REQ-020 The next head position SHALL be computed at 11-bit signed width so that X_MIN-STEP underflow is detected, not wrapped.
REQ-021 If the next head lies outside [X_MIN,X_MAX]x[Y_MIN,Y_MAX], or equals seg2 or seg3, the move SHALL be suppressed, positions held, and OVER entered next cycle.
REQ-022 OVER SHALL hold all positions and ignore frame_tick and buttons until start or rst.

Reset
REQ-023 rst=1 SHALL, at the next edge and overriding all other inputs in any state, force: IDLE; head=(START_X,START_Y); seg2/seg3/seg4 x = START_X-STEP, -2*STEP, -3*STEP; all y = START_Y; direction RIGHT; pending direction RIGHT; counter 0; black=1; game_over=0.

Configuration
REQ-024 With macro SNAKE_WRAP_EN defined, a head beyond X_MAX SHALL be placed at X_MIN and one beyond X_MIN at X_MAX (same for Y), and wall hits SHALL NOT enter OVER; self-collision still applies.
REQ-025 Without SNAKE_WRAP_EN, wall hits SHALL follow REQ-021.

Verification (FRAMES_PER_MOVE=2 unless noted)
REQ-026 Reset, then start=1 for 1 cycle -> black falls 1 cycle later; x1..x4=320,310,300,290; all y=240.
REQ-027 RUN, 2 frame_ticks -> 1 cycle after the 2nd tick x1..x4=330,320,310,300; no change after the 1st tick.
REQ-028 Direction LEFT pressed while moving RIGHT -> ignored; UP+LEFT pressed together, then next move -> y1=230, x1 unchanged.
REQ-029 STEP=10, START_X=630, moving RIGHT, move -> without SNAKE_WRAP_EN: game_over=1, x1 held at 630; with it: x1=5, game_over=0.
REQ-030 rst asserted mid-RUN with frame_tick also asserted -> next cycle IDLE, black=1, reset positions, counter 0.
